// File: rtl/nice_stream_line_arb.sv
// Line-granular round-robin arbiter: one producer owns the shared byte stream
// until it sends a newline ('\n' or '\r') or hits MAX_LINE bytes.
module nice_stream_line_arb #(
    parameter  int NUM_REQ  = 4,
    parameter  int DATA_W   = 8,
    parameter  int MAX_LINE = 256,
    localparam int SRC_W    = $clog2(NUM_REQ),
    localparam int CNT_W    = $clog2(MAX_LINE + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic [SRC_W-1:0]          out_src,
    output logic                      out_sol,
    output logic                      busy,
    output logic                      cut_evt
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state;
    logic [SRC_W-1:0]   grant;
    logic [SRC_W-1:0]   last_grant;
    logic [SRC_W-1:0]   next_grant;
    logic [SRC_W:0]     idx;
    logic               any_req;
    logic [CNT_W-1:0]   byte_cnt;
    logic [DATA_W-1:0]  slot [NUM_REQ];
    logic               fire;
    logic               is_nl;
    logic               last_byte;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            slot[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Scan farthest-to-nearest from last_grant so the nearest valid requester is the final assignment.
    always_comb begin
        next_grant = last_grant;
        any_req    = 1'b0;
        idx        = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = {1'b0, last_grant} + (SRC_W+1)'(k);
            if (idx >= (SRC_W+1)'(NUM_REQ)) begin
                idx = idx - (SRC_W+1)'(NUM_REQ);
            end
            if (req_valid[idx[SRC_W-1:0]]) begin
                next_grant = idx[SRC_W-1:0];
                any_req    = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_sol   = 1'b0;
        if (state == LOCKED) begin
            req_ready[grant] = out_ready;
            out_valid        = req_valid[grant];
            out_data         = slot[grant];
            out_sol          = (byte_cnt == '0);
        end
    end

    assign fire      = out_valid && out_ready;
    assign is_nl     = (out_data[7:0] == 8'h0A) || (out_data[7:0] == 8'h0D);
    assign last_byte = (byte_cnt == CNT_W'(MAX_LINE - 1));
    assign busy      = (state == LOCKED);
    assign out_src   = grant;

    // A newline on the final allowed byte is an ordinary release, so cut_evt stays low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= SRC_W'(NUM_REQ - 1);
            byte_cnt   <= '0;
            cut_evt    <= 1'b0;
        end else begin
            cut_evt <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant    <= next_grant;
                        byte_cnt <= '0;
                        state    <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (fire) begin
                        if (is_nl || last_byte) begin
                            state      <= IDLE;
                            last_grant <= grant;
                            byte_cnt   <= '0;
                            cut_evt    <= !is_nl;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
